// File: rtl/vjtag_pkg.sv
// Shared virtual-JTAG definitions: IR codes, default ID word and DR frame width helper.
package vjtag_pkg;
  localparam logic [1:0]  IR_READ_STATUS   = 2'b01;
  localparam logic [1:0]  IR_READ_ID       = 2'b10;
  localparam logic [15:0] ID_VALUE_DEFAULT = 16'hB1A5;

  function automatic int frame_w(input int data_w, input int seq_w, input bit parity);
    return data_w + seq_w + (parity ? 1 : 0);
  endfunction
endpackage

// File: rtl/vjtag_dr_shifter.sv
// Parallel-load, right-shift DR with a runtime serial insert position; bits above it clear.
module vjtag_dr_shifter #(
  parameter int W     = 17,
  parameter int POS_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic             tck,
  input  logic             aclr,
  input  logic             load,
  input  logic             shift,
  input  logic [W-1:0]     load_val,
  input  logic [POS_W-1:0] ins_pos,
  input  logic             sin,
  output logic             sr0
);
  logic [W-1:0] sr, nxt;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    if (gi < W-1) begin : g_mid
      assign nxt[gi] = (POS_W'(gi) == ins_pos) ? sin :
                       (POS_W'(gi) <  ins_pos) ? sr[gi+1] : 1'b0;
    end else begin : g_top
      assign nxt[gi] = (POS_W'(gi) == ins_pos) ? sin : 1'b0;
    end
  end

  always_ff @(posedge tck or posedge aclr) begin
    if (aclr)       sr <= '0;
    else if (load)  sr <= load_val;
    else if (shift) sr <= nxt;
  end

  assign sr0 = sr[0];
endmodule

// File: rtl/vjtag_readback_tx.sv
// FPGA-to-host virtual-JTAG readback: status/ID/bypass DRs shifted out on tdo in the tck domain.
// Optional macro VJTAG_TX_PARITY_EN appends an even-parity bit to the READ_STATUS frame.
module vjtag_readback_tx
  import vjtag_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              SEQ_W    = 8,
  parameter int              ID_W     = 16,
  parameter logic [ID_W-1:0] ID_VALUE = ID_VALUE_DEFAULT,
  parameter int              CNT_W    = 6
) (
  input  logic              tck,
  input  logic              aclr,
  input  logic [1:0]        ir_in,
  input  logic              v_cdr,
  input  logic              v_sdr,
  input  logic              v_udr,
  input  logic              tdi,
  input  logic [DATA_W-1:0] status_in,
  output logic              tdo,
  output logic [SEQ_W-1:0]  seq_cnt,
  output logic              rd_done,
  output logic              short_flag
);
`ifdef VJTAG_TX_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif
  localparam int FRAME_W = frame_w(DATA_W, SEQ_W, PARITY);
  localparam int SR_W    = (FRAME_W > ID_W) ? FRAME_W : ID_W;
  localparam int POS_W   = (SR_W > 1) ? $clog2(SR_W) : 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

  logic             is_rs, is_id, shift, udr, bypass, sr0;
  logic [SR_W-1:0]  load_val;
  logic [POS_W-1:0] ins_pos;
  logic [CNT_W-1:0] bitcnt;

  assign is_rs = (ir_in == IR_READ_STATUS);
  assign is_id = (ir_in == IR_READ_ID);
  assign shift = v_sdr & ~v_cdr;
  assign udr   = v_udr & ~v_cdr & ~v_sdr;

  always_comb begin
    load_val = '0;
    if (is_rs) begin
      load_val[DATA_W-1:0]    = status_in;
      load_val[DATA_W+:SEQ_W] = seq_cnt;
`ifdef VJTAG_TX_PARITY_EN
      load_val[FRAME_W-1]     = ^{seq_cnt, status_in};
`endif
    end else if (is_id) begin
      load_val[ID_W-1:0] = ID_VALUE;
    end
  end

  // Inserting tdi at the top of the active frame makes overshift echo tdi delayed by the frame width.
  assign ins_pos = is_rs ? POS_W'(FRAME_W-1) : is_id ? POS_W'(ID_W-1) : '0;

  vjtag_dr_shifter #(.W(SR_W), .POS_W(POS_W)) u_dr (
    .tck      (tck),
    .aclr     (aclr),
    .load     (v_cdr),
    .shift    (shift),
    .load_val (load_val),
    .ins_pos  (ins_pos),
    .sin      (tdi),
    .sr0      (sr0)
  );

  always_ff @(posedge tck or posedge aclr) begin
    if (aclr) begin
      bypass     <= 1'b0;
      bitcnt     <= '0;
      seq_cnt    <= '0;
      rd_done    <= 1'b0;
      short_flag <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (v_cdr) begin
        bypass <= 1'b0;
        bitcnt <= '0;
      end else if (v_sdr) begin
        bypass <= tdi;
        if (bitcnt != '1) bitcnt <= bitcnt + 1'b1;
      end else if (udr && is_rs) begin
        if (bitcnt >= FRAME_CNT) begin
          seq_cnt <= seq_cnt + 1'b1;
          rd_done <= 1'b1;
        end else begin
          short_flag <= 1'b1;
        end
      end
    end
  end

  assign tdo = (is_rs | is_id) ? sr0 : bypass;
endmodule

// File: tb/tb_vjtag_readback_tx.sv
// Directed self-checking bench for vjtag_readback_tx (DATA_W=8, SEQ_W=8, ID_W=16).
module tb_vjtag_readback_tx;
`ifdef VJTAG_TX_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif

  logic       tck = 1'b0, aclr = 1'b1;
  logic [1:0] ir_in = 2'b00;
  logic       v_cdr = 1'b0, v_sdr = 1'b0, v_udr = 1'b0, tdi = 1'b0;
  logic [7:0] status_in = 8'h00;
  logic       tdo, rd_done, short_flag;
  logic [7:0] seq_cnt;
  int         checks = 0, passed = 0;

  vjtag_readback_tx dut (
    .tck(tck), .aclr(aclr), .ir_in(ir_in), .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr),
    .tdi(tdi), .status_in(status_in), .tdo(tdo), .seq_cnt(seq_cnt),
    .rd_done(rd_done), .short_flag(short_flag)
  );

  always #5 tck = ~tck;

  task automatic do_reset();
    aclr = 1'b1; @(posedge tck); #1; aclr = 1'b0;
  endtask

  task automatic capture();
    v_cdr = 1'b1; @(posedge tck); #1; v_cdr = 1'b0;
  endtask

  // tdo is sampled before each shift edge, as the host does in Shift-DR.
  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo; tdi = din[i]; v_sdr = 1'b1;
      @(posedge tck); #1;
    end
    v_sdr = 1'b0; tdi = 1'b0;
  endtask

  task automatic update();
    v_udr = 1'b1; @(posedge tck); #1; v_udr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (tdo !== 1'b0) $display("FAIL reset_tdo got=%b exp=0", tdo); else passed++;
    checks++; if (seq_cnt !== 8'd0) $display("FAIL reset_seq got=%0d exp=0", seq_cnt); else passed++;
    checks++; if (rd_done !== 1'b0) $display("FAIL reset_rd_done got=%b exp=0", rd_done); else passed++;
    checks++; if (short_flag !== 1'b0) $display("FAIL reset_short got=%b exp=0", short_flag); else passed++;
    @(posedge tck); #1; aclr = 1'b0;
  endtask

  task automatic test_read_status();
    logic [63:0] got;
    logic [16:0] e1, e2;
`ifdef VJTAG_TX_PARITY_EN
    e1 = 17'h000A5; e2 = 17'h1013C;
`else
    e1 = 17'h000A5; e2 = 17'h0013C;
`endif
    ir_in = 2'b01; status_in = 8'hA5;
    capture(); shift_bits(FW, 64'd0, got); update();
    checks++; if (got[16:0] !== (e1 & 17'((1 << FW) - 1))) $display("FAIL rs_frame1 got=%h exp=%h", got[16:0], e1); else passed++;
    checks++; if (rd_done !== 1'b1) $display("FAIL rs_done1 got=%b exp=1", rd_done); else passed++;
    checks++; if (seq_cnt !== 8'd1) $display("FAIL rs_seq1 got=%0d exp=1", seq_cnt); else passed++;
    @(posedge tck); #1;
    checks++; if (rd_done !== 1'b0) $display("FAIL rs_done_pulse got=%b exp=0", rd_done); else passed++;
    status_in = 8'h3C;
    capture(); shift_bits(FW, 64'd0, got); update();
    checks++; if (got[16:0] !== (e2 & 17'((1 << FW) - 1))) $display("FAIL rs_frame2 got=%h exp=%h", got[16:0], e2); else passed++;
    checks++; if (seq_cnt !== 8'd2) $display("FAIL rs_seq2 got=%0d exp=2", seq_cnt); else passed++;
    // Idle cycles between frames must hold everything.
    repeat (3) @(posedge tck); #1;
    checks++; if (seq_cnt !== 8'd2 || rd_done !== 1'b0) $display("FAIL rs_hold got=%0d/%b exp=2/0", seq_cnt, rd_done); else passed++;
  endtask

  task automatic test_short_frame();
    logic [63:0] got;
    capture(); shift_bits(10, 64'd0, got); update();
    checks++; if (short_flag !== 1'b1) $display("FAIL short_flag got=%b exp=1", short_flag); else passed++;
    checks++; if (seq_cnt !== 8'd2) $display("FAIL short_seq got=%0d exp=2", seq_cnt); else passed++;
    checks++; if (rd_done !== 1'b0) $display("FAIL short_done got=%b exp=0", rd_done); else passed++;
  endtask

  task automatic test_read_id();
    logic [63:0] got;
    ir_in = 2'b10;
    capture(); shift_bits(20, 64'hFFFFF, got); update();
    checks++; if (got[15:0] !== 16'hB1A5) $display("FAIL id_frame got=%h exp=b1a5", got[15:0]); else passed++;
    checks++; if (got[19:16] !== 4'hF) $display("FAIL id_overshift got=%h exp=f", got[19:16]); else passed++;
    checks++; if (seq_cnt !== 8'd2 || rd_done !== 1'b0) $display("FAIL id_udr_side got=%0d/%b exp=2/0", seq_cnt, rd_done); else passed++;
  endtask

  task automatic test_bypass();
    logic [63:0] got;
    ir_in = 2'b00;
    capture(); shift_bits(3, 64'b101, got);
    checks++; if (got[2:0] !== 3'b010) $display("FAIL bypass got=%b exp=010", got[2:0]); else passed++;
  endtask

  task automatic test_wrap_and_aclr();
    logic [63:0] got;
    do_reset();
    ir_in = 2'b01; status_in = 8'h00;
    for (int f = 0; f < 256; f++) begin
      capture(); shift_bits(FW, 64'd0, got); update();
      if (f == 254) begin
        checks++; if (seq_cnt !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", seq_cnt); else passed++;
      end
    end
    checks++; if (seq_cnt !== 8'd0) $display("FAIL wrap_0 got=%0d exp=0", seq_cnt); else passed++;
    capture(); shift_bits(FW, 64'd0, got); update();
    capture(); shift_bits(4, 64'd0, got); update();
    status_in = 8'hFF;
    capture(); shift_bits(5, 64'd0, got);
    checks++; if (tdo !== 1'b1 || seq_cnt !== 8'd1 || short_flag !== 1'b1)
      $display("FAIL pre_aclr got=%b/%0d/%b exp=1/1/1", tdo, seq_cnt, short_flag); else passed++;
    @(negedge tck); aclr = 1'b1; #1;
    checks++; if (tdo !== 1'b0 || seq_cnt !== 8'd0 || short_flag !== 1'b0)
      $display("FAIL mid_aclr got=%b/%0d/%b exp=0/0/0", tdo, seq_cnt, short_flag); else passed++;
    @(negedge tck); aclr = 1'b0;
    @(posedge tck); #1;
    shift_bits(3, 64'h7, got);
    checks++; if (got[2:0] !== 3'b000) $display("FAIL post_aclr_tdo got=%b exp=000", got[2:0]); else passed++;
  endtask

`ifdef VJTAG_TX_PARITY_EN
  task automatic test_parity();
    logic [63:0] got;
    do_reset();
    ir_in = 2'b01; status_in = 8'h01;
    capture(); shift_bits(20, 64'h1, got);
    checks++; if (got[16:0] !== 17'h10001) $display("FAIL par_frame got=%h exp=10001", got[16:0]); else passed++;
    checks++; if (got[19:17] !== 3'b001) $display("FAIL par_insert got=%b exp=001", got[19:17]); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_read_status();
    test_short_frame();
    test_read_id();
    test_bypass();
    test_wrap_and_aclr();
`ifdef VJTAG_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
